// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD
    } state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: exception, then redirect, then sequential advance, else hold.
module pc_next_sel
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic        exc_take,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        advance,
    input  logic [31:0] pc,
    output logic [31:0] pc_next
);

    always_comb begin
        if (exc_take) begin
            pc_next = EXC_VECTOR;
        end else if (redirect_valid) begin
            pc_next = align_word(redirect_target);
        end else if (advance) begin
            pc_next = pc + PC_STEP;
        end else begin
            pc_next = pc;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the imem handshake, fills the IF/ID slot.
// Optional exception entry (exc_req / exc_epc) is enabled by defining PC_EXC_EN.
module pc_fetch_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef PC_EXC_EN
    input  logic        exc_req,
    output logic [31:0] exc_epc,
`endif
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_next;
    logic [31:0] addr_q;
    logic [31:0] skid_q;
    logic        drop_q;
    logic        if_valid_q;
    logic [31:0] if_pc_q, if_instr_q;

    logic        exc_take;
    logic        flush;
    logic        fetch_done;
    logic        take_fetch;
    logic        take_skid;
    logic        advance;

`ifdef PC_EXC_EN
    logic [31:0] exc_epc_q;
    assign exc_take = exc_req;
    assign exc_epc  = exc_epc_q;
`else
    assign exc_take = 1'b0;
`endif

    assign flush      = exc_take | redirect_valid;
    assign fetch_done = (state_q == S_FETCH) & imem_ready;
    assign take_fetch = fetch_done & ~drop_q & ~stall;
    assign take_skid  = (state_q == S_HOLD) & ~stall;
    assign advance    = take_fetch | take_skid;

    pc_next_sel #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_sel (
        .exc_take        (exc_take),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .advance         (advance),
        .pc              (pc_q),
        .pc_next         (pc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                if (!flush && fetch_done && !drop_q && stall) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (flush || !stall) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req  = (state_q == S_FETCH);
        imem_addr = addr_q;
    end

    // addr_q tracks pc_q but is frozen while a request is outstanding, so a redirect
    // into a pending fetch only moves the logical PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            drop_q     <= 1'b0;
            skid_q     <= NOP_INSTR;
            if_valid_q <= 1'b0;
            if_pc_q    <= 32'h0;
            if_instr_q <= NOP_INSTR;
        end else begin
            pc_q <= pc_next;
            if (!(imem_req && !imem_ready)) begin
                addr_q <= pc_next;
            end
            drop_q <= (state_q == S_FETCH) & ~imem_ready & (drop_q | flush);
            if (fetch_done && !flush && !drop_q && stall) begin
                skid_q <= imem_rdata;
            end
            if (flush) begin
                if_valid_q <= 1'b0;
            end else if (take_fetch) begin
                if_valid_q <= 1'b1;
                if_pc_q    <= pc_q;
                if_instr_q <= imem_rdata;
            end else if (take_skid) begin
                if_valid_q <= 1'b1;
                if_pc_q    <= pc_q;
                if_instr_q <= skid_q;
            end
        end
    end

`ifdef PC_EXC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_epc_q <= 32'h0;
        end else if (exc_req) begin
            exc_epc_q <= if_valid_q ? if_pc_q : pc_q;
        end
    end
`endif

    assign if_valid = if_valid_q;
    assign if_pc    = if_pc_q;
    assign if_instr = if_instr_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed and randomized checks for pc_fetch_ctrl against a delivered-stream scoreboard.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
`ifdef PC_EXC_EN
    logic        exc_req;
    logic [31:0] exc_epc;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
`ifdef PC_EXC_EN
        .exc_req         (exc_req),
        .exc_epc         (exc_epc),
`endif
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_instr        (if_instr)
    );

    // Instruction memory contents: a bijective function of the word address.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a ^ 32'hC3C3_5A5B;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rdy, input logic stl, input logic rv,
                         input logic [31:0] tgt);
        imem_ready      = rdy;
        stall           = stl;
        redirect_valid  = rv;
        redirect_target = tgt;
        imem_rdata      = rdy ? mem_f(imem_addr) : 32'hDEAD_BEEF;
    endtask

    initial begin
        logic [31:0] exp_next;
        logic        prev_valid, prev_req;
        logic [31:0] prev_pc, prev_instr, prev_addr;
        logic        rdy, stl, rv;
        logic [31:0] tgt;
        int          deliveries;

        rst_n = 1'b0;
`ifdef PC_EXC_EN
        exc_req = 1'b0;
`endif
        imem_ready = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        redirect_target = 32'h0; imem_rdata = 32'h0;
        step(); step();
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'b0, if_valid}, 32'd0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_instr", if_instr, 32'h0000_0013);

        // 1: back-to-back fetches with imem_ready tied high
        rst_n = 1'b1;
        drive(1, 0, 0, 0); step();
        check("t1_req", {31'b0, imem_req}, 32'd1);
        check("t1_addr0", imem_addr, 32'h0);
        check("t1_valid0", {31'b0, if_valid}, 32'd0);
        drive(1, 0, 0, 0); step();
        check("t1_addr4", imem_addr, 32'h4);
        check("t1_if_pc0", if_pc, 32'h0);
        check("t1_instr0", if_instr, mem_f(32'h0));
        check("t1_valid1", {31'b0, if_valid}, 32'd1);
        drive(1, 0, 0, 0); step();
        check("t1_addr8", imem_addr, 32'h8);
        check("t1_if_pc4", if_pc, 32'h4);

        // 2: stall for three cycles while the fetch at 8 completes
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0); step();
            check("t2_hold_pc", if_pc, 32'h4);
            check("t2_hold_req", {31'b0, imem_req}, 32'd0);
        end
        drive(1, 0, 0, 0); step();
        check("t2_if_pc8", if_pc, 32'h8);
        check("t2_instr8", if_instr, mem_f(32'h8));
        check("t2_addr_c", imem_addr, 32'hC);

        // 3: redirect into an outstanding fetch at 0xC
        drive(0, 0, 1, 32'h100); step();
        check("t3_flush", {31'b0, if_valid}, 32'd0);
        check("t3_addr_hold", imem_addr, 32'hC);
        drive(0, 0, 0, 0); step();
        drive(0, 0, 0, 0); step();
        check("t3_addr_hold2", imem_addr, 32'hC);
        drive(1, 0, 0, 0); step();
        check("t3_stale_dropped", {31'b0, if_valid}, 32'd0);
        check("t3_addr_tgt", imem_addr, 32'h100);
        drive(1, 0, 0, 0); step();
        check("t3_if_pc", if_pc, 32'h100);
        check("t3_instr", if_instr, mem_f(32'h100));
        check("t3_valid", {31'b0, if_valid}, 32'd1);

        // 4: misaligned redirect together with stall
        drive(1, 1, 1, 32'h203); step();
        check("t4_addr", imem_addr, 32'h200);
        check("t4_req", {31'b0, imem_req}, 32'd1);
        check("t4_flush", {31'b0, if_valid}, 32'd0);
        drive(1, 0, 0, 0); step();
        check("t4_if_pc", if_pc, 32'h200);
        check("t4_instr", if_instr, mem_f(32'h200));

        // 5: PC wrap
        drive(1, 0, 1, 32'hFFFF_FFFC); step();
        check("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
        drive(1, 0, 0, 0); step();
        check("t5_addr_wrap", imem_addr, 32'h0);
        check("t5_if_pc", if_pc, 32'hFFFF_FFFC);

`ifdef PC_EXC_EN
        // 6: exception beats a simultaneous redirect
        drive(1, 0, 1, 32'h40); step();
        drive(1, 0, 0, 0); step();
        check("t6_if_pc", if_pc, 32'h40);
        exc_req = 1'b1;
        drive(1, 0, 1, 32'h300); step();
        exc_req = 1'b0;
        check("t6_addr_vec", imem_addr, 32'h80);
        check("t6_epc", exc_epc, 32'h40);
        check("t6_flush", {31'b0, if_valid}, 32'd0);
`endif

        // Reset asserted in the middle of a pending fetch
        drive(0, 0, 0, 0); step();
        check("rst_mid_req_pre", {31'b0, imem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_req", {31'b0, imem_req}, 32'd0);
        check("rst_mid_addr", imem_addr, 32'h0);
        check("rst_mid_valid", {31'b0, if_valid}, 32'd0);
        check("rst_mid_if_pc", if_pc, 32'h0);
        check("rst_mid_instr", if_instr, 32'h0000_0013);
`ifdef PC_EXC_EN
        check("rst_mid_epc", exc_epc, 32'h0);
`endif
        step(); step();
        rst_n = 1'b1;

        // Randomized phase: the scoreboard only knows which PC must be delivered next.
        exp_next   = 32'h0;
        deliveries = 0;
        prev_valid = if_valid; prev_pc = if_pc; prev_instr = if_instr;
        prev_addr  = imem_addr; prev_req = imem_req;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rdy = ($urandom_range(0, 9) < 7);
            stl = ($urandom_range(0, 9) < 2);
            rv  = (cyc == 0) || ($urandom_range(0, 99) < 8);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            drive(rdy, stl, rv, tgt);
            step();
            if (rv) begin
                check("rnd_flush", {31'b0, if_valid}, 32'd0);
                exp_next = {tgt[31:2], 2'b00};
            end else if (stl) begin
                check("rnd_stall_valid", {31'b0, if_valid}, {31'b0, prev_valid});
                check("rnd_stall_pc", if_pc, prev_pc);
                check("rnd_stall_instr", if_instr, prev_instr);
            end else if (if_valid && (!prev_valid || if_pc != prev_pc)) begin
                check("rnd_stream_pc", if_pc, exp_next);
                check("rnd_stream_instr", if_instr, mem_f(if_pc));
                exp_next   = exp_next + 32'd4;
                deliveries = deliveries + 1;
            end
            if (prev_req && !rdy) begin
                check("rnd_addr_stable", imem_addr, prev_addr);
            end
            prev_valid = if_valid; prev_pc = if_pc; prev_instr = if_instr;
            prev_addr  = imem_addr; prev_req = imem_req;
        end
        check("rnd_min_deliveries", {31'b0, deliveries >= 300}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
